// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_port_arbiter                                                       |
// | Round-robin burst arbiter sharing one Cache port between two requesters, |
// | with tagged return of read data to the requester that issued the read.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cache_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              Clock_Puls,
  input  logic              Reset,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_adr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic              r0_last,
  output logic              r0_ack,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_adr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_last,
  output logic              r1_ack,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] c_adr,
  output logic              c_wr,
  output logic              c_rd,
  output logic [DATA_W-1:0] c_di,
  input  logic [DATA_W-1:0] c_do,
  output logic              owner,
  output logic              busy
);

  localparam int               CNT_W       = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_prio;
  logic              r_owner;
  logic              r_tag_valid;
  logic              r_tag_id;
  logic [CNT_W-1:0]  r_beat_cnt;

  logic              w_busy;
  logic              w_sel;
  logic              w_req;
  logic              w_wr;
  logic              w_last;
  logic              w_release;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_wdata;
  logic [CNT_W-1:0]  w_cnt_inc;

  always_comb begin
    w_busy    = (r_state == OWN0) || (r_state == OWN1);
    w_sel     = (r_state == OWN1);
    w_req     = w_busy && (w_sel ? r1_req : r0_req);
    w_wr      = w_sel ? r1_wr    : r0_wr;
    w_last    = w_sel ? r1_last  : r0_last;
    w_adr     = w_sel ? r1_adr   : r0_adr;
    w_wdata   = w_sel ? r1_wdata : r0_wdata;
    w_cnt_inc = r_beat_cnt + CNT_W'(1);
    // An idle owner gives the port up immediately rather than stalling the other side.
    w_release = w_busy && (!w_req || w_last || (w_cnt_inc == C_LAST_BEAT));
  end

  assign c_adr     = w_busy ? w_adr   : '0;
  assign c_di      = w_busy ? w_wdata : '0;
  assign c_wr      = w_req && w_wr;
  assign c_rd      = w_req && !w_wr;
  assign r0_ack    = (r_state == OWN0) && r0_req;
  assign r1_ack    = (r_state == OWN1) && r1_req;
  assign r0_rvalid = r_tag_valid && !r_tag_id;
  assign r1_rvalid = r_tag_valid &&  r_tag_id;
  assign r0_rdata  = r0_rvalid ? c_do : '0;
  assign r1_rdata  = r1_rvalid ? c_do : '0;
  assign owner     = r_owner;
  assign busy      = w_busy;

  always_ff @(posedge Clock_Puls or negedge Reset) begin
    if (!Reset) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_owner     <= 1'b0;
      r_beat_cnt  <= '0;
      r_tag_valid <= 1'b0;
      r_tag_id    <= 1'b0;
    end else begin
      // Read data returns one cycle later, independent of whether the grant survives.
      r_tag_valid <= c_rd;
      r_tag_id    <= w_sel;
      case (r_state)
        IDLE: begin
          if (r0_req && (!r1_req || !r_prio)) begin
            r_state <= OWN0;
            r_owner <= 1'b0;
          end else if (r1_req) begin
            r_state <= OWN1;
            r_owner <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (w_req) begin
            r_beat_cnt <= w_cnt_inc;
          end
          if (w_release) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_prio     <= !w_sel;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
